// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchroniser and centre-of-bit sampling.
// Presents each good byte with a 1-cycle o_Rx_DV strobe.
// Flags a low stop bit with a 1-cycle o_Frame_Err strobe.
// Optional feature: define UART_RX_MAJORITY_EN to take a 2-of-3 vote at every sample point.
// With the vote, a single-cycle glitch on the line is ignored.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_Clock,
  input  logic       reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Frame_Err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_t;

  state_t        state_r, state_n;
  logic          rx_meta_r, rx_sync_r;
  logic [CW-1:0] count_r, count_n;
  logic [2:0]    bit_idx_r, bit_idx_n;
  logic [7:0]    shift_r, shift_n;
  logic [7:0]    byte_r, byte_n;
  logic          dv_r, dv_n;
  logic          err_r, err_n;
  logic          active_r, active_n;
  logic          bit_s;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge i_Clock) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= i_Rx_Serial;
      rx_sync_r <= rx_meta_r;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic          vote_a_r, vote_b_r;
  logic [CW-1:0] sample_pt_s;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // The sample point is mid start bit while in START and the end of the bit count elsewhere.
  always_comb begin
    if (state_r == S_START) begin
      sample_pt_s = HALF;
    end else begin
      sample_pt_s = LAST;
    end
  end

  // Capture the synced line two cycles and one cycle before the sample point for the vote.
  always_ff @(posedge i_Clock) begin
    if (reset) begin
      vote_a_r <= 1'b1;
      vote_b_r <= 1'b1;
    end else begin
      if (count_r == sample_pt_s - CW'(2)) begin
        vote_a_r <= rx_sync_r;
      end else begin
        vote_a_r <= vote_a_r;
      end
      if (count_r == sample_pt_s - CW'(1)) begin
        vote_b_r <= rx_sync_r;
      end else begin
        vote_b_r <= vote_b_r;
      end
    end
  end

  assign bit_s = maj3(vote_a_r, vote_b_r, rx_sync_r);
`else
  assign bit_s = rx_sync_r;
`endif

  // Hold the FSM state, the counters and the registered outputs.
  always_ff @(posedge i_Clock) begin
    if (reset) begin
      state_r   <= S_IDLE;
      count_r   <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      byte_r    <= 8'h00;
      dv_r      <= 1'b0;
      err_r     <= 1'b0;
      active_r  <= 1'b0;
    end else begin
      state_r   <= state_n;
      count_r   <= count_n;
      bit_idx_r <= bit_idx_n;
      shift_r   <= shift_n;
      byte_r    <= byte_n;
      dv_r      <= dv_n;
      err_r     <= err_n;
      active_r  <= active_n;
    end
  end

  // Compute the next state; the strobes default low so each one lasts a single cycle.
  always_comb begin
    state_n   = state_r;
    count_n   = count_r;
    bit_idx_n = bit_idx_r;
    shift_n   = shift_r;
    byte_n    = byte_r;
    dv_n      = 1'b0;
    err_n     = 1'b0;
    active_n  = active_r;
    case (state_r)
      S_IDLE: begin
        count_n   = '0;
        bit_idx_n = 3'd0;
        if (!rx_sync_r) begin
          state_n  = S_START;
          active_n = 1'b1;
        end else begin
          active_n = 1'b0;
        end
      end
      S_START: begin
        if (count_r == HALF) begin
          count_n = '0;
          if (!bit_s) begin
            state_n = S_DATA;
          end else begin
            state_n  = S_IDLE;
            active_n = 1'b0;
          end
        end else begin
          count_n = count_r + CW'(1);
        end
      end
      S_DATA: begin
        if (count_r == LAST) begin
          count_n = '0;
          shift_n[bit_idx_r] = bit_s;
          if (bit_idx_r == 3'd7) begin
            bit_idx_n = 3'd0;
            state_n   = S_STOP;
          end else begin
            bit_idx_n = bit_idx_r + 3'd1;
          end
        end else begin
          count_n = count_r + CW'(1);
        end
      end
      S_STOP: begin
        if (count_r == LAST) begin
          count_n = '0;
          state_n = S_CLEANUP;
          if (bit_s) begin
            byte_n = shift_r;
            dv_n   = 1'b1;
          end else begin
            err_n  = 1'b1;
          end
        end else begin
          count_n = count_r + CW'(1);
        end
      end
      S_CLEANUP: begin
        // Wait out a stuck-low line (break or bad stop bit) before re-arming.
        if (rx_sync_r) begin
          state_n  = S_IDLE;
          active_n = 1'b0;
        end else begin
          state_n  = S_CLEANUP;
        end
      end
      default: begin
        state_n   = S_IDLE;
        count_n   = '0;
        bit_idx_n = 3'd0;
        active_n  = 1'b0;
      end
    endcase
  end

  assign o_Rx_DV     = dv_r;
  assign o_Rx_Byte   = byte_r;
  assign o_Rx_Active = active_r;
  assign o_Frame_Err = err_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked against a queue-based reference model.
// The bench builds with or without UART_RX_MAJORITY_EN and expects the matching glitch result.
module tb_uart_rx;

  localparam int C    = 434;
  localparam int HALF = (C - 1) / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       dv, act, ferr;
  logic [7:0] rbyte;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock(clk), .reset(reset), .i_Rx_Serial(rx),
    .o_Rx_DV(dv), .o_Rx_Byte(rbyte), .o_Rx_Active(act), .o_Frame_Err(ferr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected events in frame order, {is_err, byte}.
  logic [8:0]  exp_q[$];
  logic [8:0]  mon_e;
  logic [7:0]  last_good;
  logic        prev_dv, prev_err;
  int unsigned last_dv_cyc;
  int          act_len, last_act_len;

  // Monitor: compare every strobe against the model queue and track active pulse widths.
  always @(negedge clk) begin
    if (reset) begin
      last_good <= 8'h00;
      prev_dv   <= 1'b0;
      prev_err  <= 1'b0;
      act_len   <= 0;
    end else begin
      if (dv || ferr) begin
        check_eq("dv_err_excl", 32'(dv & ferr), 32'd0);
        check_eq("strobe_width", 32'((dv & prev_dv) | (ferr & prev_err)), 32'd0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_strobe", 32'({dv, ferr}), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("strobe_kind", 32'(ferr), 32'(mon_e[8]));
          if (mon_e[8]) begin
            check_eq("byte_held", 32'(rbyte), 32'(last_good));
          end else begin
            check_eq("rx_byte", 32'(rbyte), 32'(mon_e[7:0]));
            last_good <= mon_e[7:0];
          end
        end
        if (dv) last_dv_cyc <= cyc;
      end
      prev_dv  <= dv;
      prev_err <= ferr;
      if (act) begin
        act_len <= act_len + 1;
      end else if (act_len != 0) begin
        last_act_len <= act_len;
        act_len      <= 0;
      end
    end
  end

  int unsigned t0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_good(input logic [7:0] b);
    exp_q.push_back({1'b0, b});
  endtask

  task automatic expect_err();
    exp_q.push_back({1'b1, 8'h00});
  endtask

  // Drive one 8N1 frame; optionally invert the line for one cycle at each data bit centre.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch);
    logic [9:0] fb;
    fb = {stop, b, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = fb[i];
      if (glitch && i >= 1 && i <= 8) begin
        repeat (HALF + 1) tick();
        rx = ~fb[i];
        tick();
        rx = fb[i];
        repeat (C - HALF - 2) tick();
      end else begin
        repeat (C) tick();
      end
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    int         gap;

    repeat (4) tick();
    reset = 1'b0;
    tick();
    check_eq("rst_dv", 32'(dv), 32'd0);
    check_eq("rst_err", 32'(ferr), 32'd0);
    check_eq("rst_active", 32'(act), 32'd0);
    check_eq("rst_byte", 32'(rbyte), 32'h00);

    // Single good frame, with the strobe latency measured from the falling edge.
    expect_good(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (3) tick();
    check_eq("dv_latency", last_dv_cyc - t0 - 1, 32'(3 + HALF + 9 * C));
    check_eq("pending_t1", 32'(exp_q.size()), 32'd0);

    // False start: the line is low for 100 cycles only.
    rx = 1'b0;
    repeat (100) tick();
    rx = 1'b1;
    repeat (HALF + 20) tick();
    check_eq("false_start_active", 32'(act), 32'd0);
    check_eq("false_start_len", 32'(last_act_len >= 100 && last_act_len <= HALF + 4), 32'd1);

    // Framing error, then the line stuck low; afterwards a good byte.
    expect_err();
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (3000) tick();
    check_eq("stuck_low_active", 32'(act), 32'd1);
    check_eq("ferr_byte_held", 32'(rbyte), 32'hA5);
    rx = 1'b1;
    repeat (6) tick();
    check_eq("stuck_release_active", 32'(act), 32'd0);
    expect_good(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    repeat (3) tick();
    check_eq("pending_t3", 32'(exp_q.size()), 32'd0);

    // Back-to-back frames with no idle gap.
    expect_good(8'h00);
    expect_good(8'hFF);
    expect_good(8'h5A);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (3) tick();
    check_eq("pending_t4", 32'(exp_q.size()), 32'd0);
    check_eq("b2b_last_byte", 32'(rbyte), 32'h5A);

    // Reset during data bit 4; the rest of the aborted frame is all ones.
    fork
      send_frame(8'hF0, 1'b1, 1'b0);
      begin
        repeat (5 * C + C / 2) tick();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_eq("midrst_dv", 32'(dv), 32'd0);
        check_eq("midrst_err", 32'(ferr), 32'd0);
        check_eq("midrst_active", 32'(act), 32'd0);
        check_eq("midrst_byte", 32'(rbyte), 32'h00);
      end
    join
    repeat (10) tick();
    check_eq("midrst_quiet", 32'(act), 32'd0);
    expect_good(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0);
    repeat (3) tick();
    check_eq("pending_t5", 32'(exp_q.size()), 32'd0);

    // One-cycle glitch at each data bit centre: rejected only with the vote enabled.
`ifdef UART_RX_MAJORITY_EN
    expect_good(8'h55);
`else
    expect_good(8'hAA);
`endif
    send_frame(8'h55, 1'b1, 1'b1);
    repeat (3) tick();
    check_eq("pending_t6", 32'(exp_q.size()), 32'd0);

    // Random frames with random gaps; a bad stop bit always gets a short high gap afterwards.
    for (int k = 0; k < 4; k++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      if (rs) expect_good(rb);
      else    expect_err();
      send_frame(rb, rs, 1'b0);
      rx = 1'b1;
      gap = rs ? $urandom_range(0, 40) : $urandom_range(3, 40);
      repeat (gap) tick();
    end
    repeat (10) tick();
    check_eq("pending_rand", 32'(exp_q.size()), 32'd0);
    check_eq("final_idle", 32'(act), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
